pipeline_hazard_ctrl: RTL and testbench

Central stall/flush scheduler for the 5-stage MIPS pipeline. It drives the write-enable and flush controls of the PC, IF/ID, ID/EX and EX/MEM registers, and handles three cases: load-use hazards, taken branches resolved in MEM, and a variable-latency data-memory handshake with timeout. It also keeps saturating stall and flush counters for performance debug.

---
 rtl/pipeline_hazard_ctrl.sv | 149 ++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush scheduler for a 5-stage MIPS pipeline: load-use interlock, MEM-stage
// branch flush and data-memory wait with timeout, plus saturating perf counters.
module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [4:0]       IFID_Rs,
  input  logic [4:0]       IFID_Rt,
  input  logic             IDEX_MemRead,
  input  logic [4:0]       IDEX_Rt,
  input  logic             EXMEM_Branch,
  input  logic             EXMEM_Zero,
  input  logic             EXMEM_MemRead,
  input  logic             EXMEM_MemWrite,
  input  logic             Mem_Ready,
  output logic             Mem_Req,
  output logic             PC_Write,
  output logic             IFID_Write,
  output logic             IDEX_Write,
  output logic             EXMEM_Write,
  output logic             IFID_Flush,
  output logic             IDEX_Bubble,
  output logic             EXMEM_Flush,
  output logic             MEMWB_Bubble,
  output logic             PCSrc,
  output logic             Mem_Error,
  output logic [CNT_W-1:0] Stall_Count,
  output logic [CNT_W-1:0] Flush_Count
);

  localparam logic [0:0] RUN      = 1'b0;
  localparam logic [0:0] MEM_WAIT = 1'b1;
  localparam int WCW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WCW-1:0]   WAIT_LAST = WCW'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  logic [0:0]       state_q, state_d;
  logic [WCW-1:0]   wait_cnt_q, wait_cnt_d;
  logic             mem_error_q, mem_error_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic memop_s, timeout_s, mem_stall_s, branch_taken_s, load_use_s;

  assign memop_s        = EXMEM_MemRead | EXMEM_MemWrite;
  assign timeout_s      = (state_q == MEM_WAIT) && !Mem_Ready && (wait_cnt_q == WAIT_LAST);
  assign mem_stall_s    = ((state_q == RUN) && memop_s && !Mem_Ready) ||
                          ((state_q == MEM_WAIT) && !Mem_Ready && !timeout_s);
  assign branch_taken_s = EXMEM_Branch & EXMEM_Zero;
  assign load_use_s     = IDEX_MemRead && (IDEX_Rt != 5'd0) &&
                          ((IDEX_Rt == IFID_Rs) || (IDEX_Rt == IFID_Rt));

  // Pipeline controls and next-state; a memory freeze masks branch and load-use.
  always_comb begin
    Mem_Req      = memop_s;
    PC_Write     = 1'b1;
    IFID_Write   = 1'b1;
    IDEX_Write   = 1'b1;
    EXMEM_Write  = 1'b1;
    IFID_Flush   = 1'b0;
    IDEX_Bubble  = 1'b0;
    EXMEM_Flush  = 1'b0;
    MEMWB_Bubble = 1'b0;
    PCSrc        = 1'b0;
    state_d      = RUN;
    wait_cnt_d   = '0;
    mem_error_d  = mem_error_q;
    stall_cnt_d  = stall_cnt_q;
    flush_cnt_d  = flush_cnt_q;

    if (Reset) begin
      Mem_Req      = 1'b0;
      PC_Write     = 1'b0;
      IFID_Write   = 1'b0;
      IDEX_Write   = 1'b0;
      EXMEM_Write  = 1'b0;
      IFID_Flush   = 1'b1;
      IDEX_Bubble  = 1'b1;
      EXMEM_Flush  = 1'b1;
      MEMWB_Bubble = 1'b1;
      mem_error_d  = 1'b0;
      stall_cnt_d  = '0;
      flush_cnt_d  = '0;
    end else begin
      if (mem_stall_s) begin
        PC_Write     = 1'b0;
        IFID_Write   = 1'b0;
        IDEX_Write   = 1'b0;
        EXMEM_Write  = 1'b0;
        MEMWB_Bubble = 1'b1;
        state_d      = MEM_WAIT;
        wait_cnt_d   = (state_q == RUN) ? WCW'(1) : wait_cnt_q + WCW'(1);
      end else if (branch_taken_s) begin
        PCSrc       = 1'b1;
        IFID_Flush  = 1'b1;
        IDEX_Bubble = 1'b1;
        EXMEM_Flush = 1'b1;
      end else if (load_use_s) begin
        PC_Write    = 1'b0;
        IFID_Write  = 1'b0;
        IDEX_Bubble = 1'b1;
      end else begin
        PCSrc = 1'b0;
      end

      if (timeout_s) begin
        mem_error_d = 1'b1;
      end else begin
        mem_error_d = mem_error_q;
      end

      if (!PC_Write && (stall_cnt_q != CNT_MAX)) begin
        stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end else begin
        stall_cnt_d = stall_cnt_q;
      end

      if (PCSrc && (flush_cnt_q != CNT_MAX)) begin
        flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end else begin
        flush_cnt_d = flush_cnt_q;
      end
    end
  end

  // State, wait counter, sticky error and perf counters.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= RUN;
      wait_cnt_q  <= '0;
      mem_error_q <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_error_q <= mem_error_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign Mem_Error   = mem_error_q;
  assign Stall_Count = stall_cnt_q;
  assign Flush_Count = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: a default instance plus a CNT_W=4
// instance sharing the same stimulus to observe counter saturation.
module tb_pipeline_hazard_ctrl;

  logic Clk, Reset;
  logic [4:0] IFID_Rs, IFID_Rt, IDEX_Rt;
  logic IDEX_MemRead, EXMEM_Branch, EXMEM_Zero, EXMEM_MemRead, EXMEM_MemWrite, Mem_Ready;

  logic Mem_Req, PC_Write, IFID_Write, IDEX_Write, EXMEM_Write;
  logic IFID_Flush, IDEX_Bubble, EXMEM_Flush, MEMWB_Bubble, PCSrc, Mem_Error;
  logic [15:0] Stall_Count, Flush_Count;

  logic s_Mem_Req, s_PC_Write, s_IFID_Write, s_IDEX_Write, s_EXMEM_Write;
  logic s_IFID_Flush, s_IDEX_Bubble, s_EXMEM_Flush, s_MEMWB_Bubble, s_PCSrc, s_Mem_Error;
  logic [3:0] s_Stall_Count, s_Flush_Count;

  int checks = 0;
  int failures = 0;

  // ctrl bit order: Mem_Req PC_Write IFID_Write IDEX_Write EXMEM_Write IFID_Flush IDEX_Bubble EXMEM_Flush MEMWB_Bubble PCSrc
  localparam logic [9:0] C_RESET  = 10'b0000011110;
  localparam logic [9:0] C_IDLE   = 10'b0111100000;
  localparam logic [9:0] C_LU     = 10'b0001101000;
  localparam logic [9:0] C_BRANCH = 10'b0111111101;
  localparam logic [9:0] C_MSTALL = 10'b1000000010;
  localparam logic [9:0] C_MDONE  = 10'b1111100000;

  wire [9:0] ctrl   = {Mem_Req, PC_Write, IFID_Write, IDEX_Write, EXMEM_Write,
                       IFID_Flush, IDEX_Bubble, EXMEM_Flush, MEMWB_Bubble, PCSrc};
  wire [9:0] s_ctrl = {s_Mem_Req, s_PC_Write, s_IFID_Write, s_IDEX_Write, s_EXMEM_Write,
                       s_IFID_Flush, s_IDEX_Bubble, s_EXMEM_Flush, s_MEMWB_Bubble, s_PCSrc};

  pipeline_hazard_ctrl dut (
    .Clk(Clk), .Reset(Reset), .IFID_Rs(IFID_Rs), .IFID_Rt(IFID_Rt),
    .IDEX_MemRead(IDEX_MemRead), .IDEX_Rt(IDEX_Rt), .EXMEM_Branch(EXMEM_Branch),
    .EXMEM_Zero(EXMEM_Zero), .EXMEM_MemRead(EXMEM_MemRead), .EXMEM_MemWrite(EXMEM_MemWrite),
    .Mem_Ready(Mem_Ready), .Mem_Req(Mem_Req), .PC_Write(PC_Write), .IFID_Write(IFID_Write),
    .IDEX_Write(IDEX_Write), .EXMEM_Write(EXMEM_Write), .IFID_Flush(IFID_Flush),
    .IDEX_Bubble(IDEX_Bubble), .EXMEM_Flush(EXMEM_Flush), .MEMWB_Bubble(MEMWB_Bubble),
    .PCSrc(PCSrc), .Mem_Error(Mem_Error), .Stall_Count(Stall_Count), .Flush_Count(Flush_Count)
  );

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(16), .CNT_W(4)) dut_small (
    .Clk(Clk), .Reset(Reset), .IFID_Rs(IFID_Rs), .IFID_Rt(IFID_Rt),
    .IDEX_MemRead(IDEX_MemRead), .IDEX_Rt(IDEX_Rt), .EXMEM_Branch(EXMEM_Branch),
    .EXMEM_Zero(EXMEM_Zero), .EXMEM_MemRead(EXMEM_MemRead), .EXMEM_MemWrite(EXMEM_MemWrite),
    .Mem_Ready(Mem_Ready), .Mem_Req(s_Mem_Req), .PC_Write(s_PC_Write), .IFID_Write(s_IFID_Write),
    .IDEX_Write(s_IDEX_Write), .EXMEM_Write(s_EXMEM_Write), .IFID_Flush(s_IFID_Flush),
    .IDEX_Bubble(s_IDEX_Bubble), .EXMEM_Flush(s_EXMEM_Flush), .MEMWB_Bubble(s_MEMWB_Bubble),
    .PCSrc(s_PCSrc), .Mem_Error(s_Mem_Error), .Stall_Count(s_Stall_Count), .Flush_Count(s_Flush_Count)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_idle();
    IFID_Rs = 5'd0; IFID_Rt = 5'd0; IDEX_MemRead = 1'b0; IDEX_Rt = 5'd0;
    EXMEM_Branch = 1'b0; EXMEM_Zero = 1'b0; EXMEM_MemRead = 1'b0;
    EXMEM_MemWrite = 1'b0; Mem_Ready = 1'b0;
  endtask

  // Advance one edge, then settle 1 time unit past it before new drives.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic load_use_inputs();
    IDEX_MemRead = 1'b1; IDEX_Rt = 5'd8; IFID_Rs = 5'd8; IFID_Rt = 5'd3;
  endtask

  initial begin
    Reset = 1'b1;
    set_idle();
    #2;
    chk("reset_ctrl", {22'd0, ctrl}, {22'd0, C_RESET});
    tick();
    chk("reset_ctrl_small", {22'd0, s_ctrl}, {22'd0, C_RESET});
    tick();
    Reset = 1'b0;
    #1;
    chk("idle_ctrl", {22'd0, ctrl}, {22'd0, C_IDLE});
    chk("idle_stall_cnt", {16'd0, Stall_Count}, 32'd0);
    chk("idle_flush_cnt", {16'd0, Flush_Count}, 32'd0);
    chk("idle_mem_error", {31'd0, Mem_Error}, 32'd0);

    // load-use on rs
    load_use_inputs();
    #1;
    chk("lu_ctrl", {22'd0, ctrl}, {22'd0, C_LU});
    tick();
    set_idle();
    #1;
    chk("lu_released", {22'd0, ctrl}, {22'd0, C_IDLE});
    chk("lu_stall_cnt", {16'd0, Stall_Count}, 32'd1);
    // load into $zero never interlocks
    IDEX_MemRead = 1'b1; IDEX_Rt = 5'd0; IFID_Rs = 5'd0; IFID_Rt = 5'd0;
    #1;
    chk("lu_r0_ctrl", {22'd0, ctrl}, {22'd0, C_IDLE});
    tick();
    chk("lu_r0_stall_cnt", {16'd0, Stall_Count}, 32'd1);

    // taken branch overrides a simultaneous load-use match
    set_idle();
    load_use_inputs();
    EXMEM_Branch = 1'b1; EXMEM_Zero = 1'b1;
    #1;
    chk("br_ctrl", {22'd0, ctrl}, {22'd0, C_BRANCH});
    tick();
    set_idle();
    chk("br_flush_cnt", {16'd0, Flush_Count}, 32'd1);
    chk("br_stall_cnt", {16'd0, Stall_Count}, 32'd1);
    EXMEM_Branch = 1'b1; EXMEM_Zero = 1'b0;
    #1;
    chk("br_nt_ctrl", {22'd0, ctrl}, {22'd0, C_IDLE});
    tick();
    chk("br_nt_flush_cnt", {16'd0, Flush_Count}, 32'd1);

    // memory wait of 3 cycles, released on the ready cycle
    set_idle();
    EXMEM_MemRead = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("mw_stall%0d", i), {22'd0, ctrl}, {22'd0, C_MSTALL});
      tick();
    end
    Mem_Ready = 1'b1;
    #1;
    chk("mw_done_ctrl", {22'd0, ctrl}, {22'd0, C_MDONE});
    tick();
    set_idle();
    #1;
    chk("mw_back_run", {22'd0, ctrl}, {22'd0, C_IDLE});
    chk("mw_stall_cnt", {16'd0, Stall_Count}, 32'd4);
    chk("mw_mem_error", {31'd0, Mem_Error}, 32'd0);

    // timeout: ready never comes
    EXMEM_MemWrite = 1'b1;
    for (int i = 0; i < 15; i++) begin
      #1;
      chk($sformatf("to_stall%0d", i), {22'd0, ctrl}, {22'd0, C_MSTALL});
      tick();
    end
    #1;
    chk("to_advance_ctrl", {22'd0, ctrl}, {22'd0, C_MDONE});
    tick();
    set_idle();
    #1;
    chk("to_mem_error", {31'd0, Mem_Error}, 32'd1);
    chk("to_stall_cnt", {16'd0, Stall_Count}, 32'd19);
    chk("to_back_run", {22'd0, ctrl}, {22'd0, C_IDLE});
    tick(); tick(); tick();
    chk("to_error_sticky", {31'd0, Mem_Error}, 32'd1);

    // reset during the second wait cycle
    EXMEM_MemRead = 1'b1;
    tick();
    Reset = 1'b1;
    #1;
    chk("rst_wait_ctrl", {22'd0, ctrl}, {22'd0, C_RESET});
    tick();
    Reset = 1'b0;
    set_idle();
    #1;
    chk("rst_wait_run", {22'd0, ctrl}, {22'd0, C_IDLE});
    chk("rst_wait_error", {31'd0, Mem_Error}, 32'd0);
    chk("rst_wait_stall_cnt", {16'd0, Stall_Count}, 32'd0);
    chk("rst_small_flush_cnt", {28'd0, s_Flush_Count}, 32'd0);

    // 20 load-use stalls: 4-bit counter saturates at 15
    load_use_inputs();
    for (int i = 0; i < 20; i++) tick();
    set_idle();
    #1;
    chk("sat_small_stall_cnt", {28'd0, s_Stall_Count}, 32'd15);
    chk("sat_wide_stall_cnt", {16'd0, Stall_Count}, 32'd20);
    chk("sat_small_mem_error", {31'd0, s_Mem_Error}, 32'd0);
    tick();
    chk("sat_small_hold", {28'd0, s_Stall_Count}, 32'd15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
